// File: rtl/dma_pkg.sv
// Shared constants, types and byte-lane helpers for the DMA address/word-count bank.
package dma_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned AW     = 16;
    localparam int unsigned CHW    = 2;
    localparam int unsigned BW     = 8;

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW-1:0] wc_t;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic           is_wc;
    } prog_sel_t;

    // Replace one byte lane of a 16-bit register, lane chosen by the byte pointer.
    function automatic logic [AW-1:0] put_byte(input logic [AW-1:0] w,
                                               input logic           hi,
                                               input logic [BW-1:0]  b);
        return hi ? {b, w[BW-1:0]} : {w[AW-1:BW], b};
    endfunction

    // Extract one byte lane of a 16-bit register.
    function automatic logic [BW-1:0] get_byte(input logic [AW-1:0] w,
                                               input logic           hi);
        return hi ? w[AW-1:BW] : w[BW-1:0];
    endfunction

endpackage

// File: rtl/dma_addr_wc_gen_if.sv
// Programming, transfer-control and Addr/WC/TC signals of the address/word-count bank.
interface dma_addr_wc_gen_if;
    import dma_pkg::*;

    logic              prog_wr;
    logic              prog_rd;
    prog_sel_t         prog_sel;
    logic [BW-1:0]     data_in;
    logic [BW-1:0]     data_out;
    logic              clr_ff;
    logic              master_clr;
    logic              status_rd;
    logic              xfer_step;
    logic [CHW-1:0]    act_ch;
    logic [NUM_CH-1:0] addr_dec;
    logic [NUM_CH-1:0] autoinit;
    addr_t             Addr;
    wc_t               WC;
    logic [NUM_CH-1:0] TC;
    logic              tc_pulse;

    // Controller / CPU side
    modport master (
        output prog_wr, prog_rd, prog_sel, data_in, clr_ff, master_clr,
               status_rd, xfer_step, act_ch, addr_dec, autoinit,
        input  data_out, Addr, WC, TC, tc_pulse
    );

    // Register bank side
    modport slave (
        input  prog_wr, prog_rd, prog_sel, data_in, clr_ff, master_clr,
               status_rd, xfer_step, act_ch, addr_dec, autoinit,
        output data_out, Addr, WC, TC, tc_pulse
    );

endinterface

// File: rtl/dma_chan_ctr.sv
// One DMA channel: base/current address and word count, step/reload and TC detection.
module dma_chan_ctr
    import dma_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic          wr_wc,
    input  logic          wr_hi,
    input  logic [BW-1:0] wr_data,
    input  logic          step,
    input  logic          dec,
    input  logic          autoinit,
    output addr_t         cur_addr,
    output wc_t           cur_wc,
    output logic          tc_evt_c
);

    addr_t base_addr;
    wc_t   base_wc;
    addr_t step_addr_c;
    wc_t   step_wc_c;

    // A step taken while the count is zero rolls over and is the terminal count.
    assign tc_evt_c    = step && (cur_wc == '0);
    assign step_addr_c = dec ? (cur_addr - AW'(1)) : (cur_addr + AW'(1));
    assign step_wc_c   = cur_wc - AW'(1);

    // Register update: clear, then byte write, then transfer step / autoinit reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_addr <= '0;
            base_wc   <= '0;
            cur_addr  <= '0;
            cur_wc    <= '0;
        end else if (clr) begin
            base_addr <= '0;
            base_wc   <= '0;
            cur_addr  <= '0;
            cur_wc    <= '0;
        end else if (wr_en) begin
            if (wr_wc) begin
                base_wc <= put_byte(base_wc, wr_hi, wr_data);
                cur_wc  <= put_byte(cur_wc, wr_hi, wr_data);
            end else begin
                base_addr <= put_byte(base_addr, wr_hi, wr_data);
                cur_addr  <= put_byte(cur_addr, wr_hi, wr_data);
            end
        end else if (step) begin
            if (tc_evt_c && autoinit) begin
                cur_addr <= base_addr;
                cur_wc   <= base_wc;
            end else begin
                cur_addr <= step_addr_c;
                cur_wc   <= step_wc_c;
            end
        end
    end

endmodule

// File: rtl/dma_addr_wc_gen.sv
// 8237A-style per-channel address/word-count bank with byte-serial programming.
module dma_addr_wc_gen
    import dma_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    dma_addr_wc_gen_if.slave  bus
);

    logic              ff;
    addr_t             cur_addr [NUM_CH];
    wc_t               cur_wc   [NUM_CH];
    logic [NUM_CH-1:0] wr_en_c;
    logic [NUM_CH-1:0] step_c;
    logic [NUM_CH-1:0] tc_evt_c;
    logic [AW-1:0]     rd_word_c;
    logic [BW-1:0]     data_out_r;
    logic [NUM_CH-1:0] tc_r;
    logic              tc_pulse_r;

    // Per-channel write decode; a write to a channel drops that channel's step.
    always_comb begin
        wr_en_c = '0;
        step_c  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_en_c[i] = bus.prog_wr && (bus.prog_sel.ch == CHW'(i));
            step_c[i]  = bus.xfer_step && (bus.act_ch == CHW'(i)) && !wr_en_c[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dma_chan_ctr u_ctr (
            .clk      (CLK),
            .rst_n    (RESET),
            .clr      (bus.master_clr),
            .wr_en    (wr_en_c[g]),
            .wr_wc    (bus.prog_sel.is_wc),
            .wr_hi    (ff),
            .wr_data  (bus.data_in),
            .step     (step_c[g]),
            .dec      (bus.addr_dec[g]),
            .autoinit (bus.autoinit[g]),
            .cur_addr (cur_addr[g]),
            .cur_wc   (cur_wc[g]),
            .tc_evt_c (tc_evt_c[g])
        );
    end

    // Current register selected for CPU readback.
    assign rd_word_c = bus.prog_sel.is_wc ? cur_wc[bus.prog_sel.ch] : cur_addr[bus.prog_sel.ch];

    // Byte pointer: clear wins over the toggle from any CPU access.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ff <= 1'b0;
        end else if (bus.master_clr || bus.clr_ff) begin
            ff <= 1'b0;
        end else if (bus.prog_wr || bus.prog_rd) begin
            ff <= ~ff;
        end
    end

    // Readback byte; a read coinciding with a write is ignored.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            data_out_r <= '0;
        end else if (bus.master_clr) begin
            data_out_r <= '0;
        end else if (bus.prog_rd && !bus.prog_wr) begin
            data_out_r <= get_byte(rd_word_c, ff);
        end
    end

    // Sticky TC bits and the one-cycle EOP pulse; a new TC beats a status read.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tc_r       <= '0;
            tc_pulse_r <= 1'b0;
        end else if (bus.master_clr) begin
            tc_r       <= '0;
            tc_pulse_r <= 1'b0;
        end else begin
            tc_r       <= (bus.status_rd ? '0 : tc_r) | tc_evt_c;
            tc_pulse_r <= |tc_evt_c;
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.TC       = tc_r;
    assign bus.tc_pulse = tc_pulse_r;
    assign bus.Addr     = cur_addr[bus.act_ch];
    assign bus.WC       = cur_wc[bus.act_ch];

endmodule

// File: tb/tb_dma_addr_wc_gen.sv
// Self-checking bench for dma_addr_wc_gen: directed scenarios plus randomized traffic vs a reference model.
module tb_dma_addr_wc_gen;
    import dma_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    dma_addr_wc_gen_if bus();

    dma_addr_wc_gen dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_ba [4];
    logic [15:0] m_bw [4];
    logic [15:0] m_ca [4];
    logic [15:0] m_cw [4];
    logic        m_ff;
    logic [3:0]  m_tc;
    logic        m_pulse;
    logic [7:0]  m_dout;

    function automatic void mdl_clear();
        for (int i = 0; i < 4; i++) begin
            m_ba[i] = 16'h0; m_bw[i] = 16'h0; m_ca[i] = 16'h0; m_cw[i] = 16'h0;
        end
        m_ff = 1'b0; m_tc = 4'h0; m_pulse = 1'b0; m_dout = 8'h0;
    endfunction

    // Effect of one clock edge given the inputs currently driven.
    function automatic void mdl_cycle();
        int          c;
        int          a;
        logic [15:0] w;
        logic [15:0] hi_val;
        logic [15:0] lo_val;
        logic [3:0]  evt;
        if (bus.master_clr) begin
            mdl_clear();
            return;
        end
        evt = 4'h0;
        c = int'(bus.prog_sel.ch);
        a = int'(bus.act_ch);
        if (bus.prog_rd && !bus.prog_wr) begin
            w = bus.prog_sel.is_wc ? m_cw[c] : m_ca[c];
            m_dout = m_ff ? w[15:8] : w[7:0];
        end
        if (bus.xfer_step && !(bus.prog_wr && c == a)) begin
            if (m_cw[a] == 16'h0) evt[a] = 1'b1;
            if (evt[a] && bus.autoinit[a]) begin
                m_ca[a] = m_ba[a];
                m_cw[a] = m_bw[a];
            end else begin
                m_ca[a] = bus.addr_dec[a] ? (m_ca[a] - 16'd1) : (m_ca[a] + 16'd1);
                m_cw[a] = m_cw[a] - 16'd1;
            end
        end
        if (bus.prog_wr) begin
            hi_val = {bus.data_in, 8'h00};
            lo_val = {8'h00, bus.data_in};
            if (bus.prog_sel.is_wc) begin
                m_bw[c] = m_ff ? ((m_bw[c] & 16'h00FF) | hi_val) : ((m_bw[c] & 16'hFF00) | lo_val);
                m_cw[c] = m_ff ? ((m_cw[c] & 16'h00FF) | hi_val) : ((m_cw[c] & 16'hFF00) | lo_val);
            end else begin
                m_ba[c] = m_ff ? ((m_ba[c] & 16'h00FF) | hi_val) : ((m_ba[c] & 16'hFF00) | lo_val);
                m_ca[c] = m_ff ? ((m_ca[c] & 16'h00FF) | hi_val) : ((m_ca[c] & 16'hFF00) | lo_val);
            end
        end
        if (bus.clr_ff) m_ff = 1'b0;
        else if (bus.prog_wr || bus.prog_rd) m_ff = ~m_ff;
        m_tc    = (bus.status_rd ? 4'h0 : m_tc) | evt;
        m_pulse = |evt;
    endfunction

    task automatic clear_strobes();
        bus.prog_wr = 1'b0; bus.prog_rd = 1'b0; bus.clr_ff = 1'b0;
        bus.master_clr = 1'b0; bus.status_rd = 1'b0; bus.xfer_step = 1'b0;
    endtask

    // Advance one clock, keeping the model in lockstep; sample 1 time unit after the edge.
    task automatic tick();
        mdl_cycle();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic wr_byte(input int ch, input logic is_wc, input logic [7:0] b);
        bus.prog_wr = 1'b1; bus.prog_sel.ch = 2'(ch); bus.prog_sel.is_wc = is_wc; bus.data_in = b;
        tick();
    endtask

    task automatic rd_byte(input int ch, input logic is_wc);
        bus.prog_rd = 1'b1; bus.prog_sel.ch = 2'(ch); bus.prog_sel.is_wc = is_wc;
        tick();
    endtask

    task automatic test_reset();
        clear_strobes();
        bus.prog_sel = '0; bus.data_in = 8'h0; bus.act_ch = 2'd0;
        bus.addr_dec = 4'h0; bus.autoinit = 4'h0;
        rst_n = 1'b0;
        mdl_clear();
        #23;
        checks++; if (bus.Addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0000", bus.Addr); end
        checks++; if (bus.WC !== 16'h0) begin failures++; $display("FAIL reset_wc got=%h exp=0000", bus.WC); end
        checks++; if (bus.TC !== 4'h0) begin failures++; $display("FAIL reset_tc got=%b exp=0000", bus.TC); end
        checks++; if (bus.tc_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", bus.tc_pulse); end
        checks++; if (bus.data_out !== 8'h0) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.data_out); end
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_prog_readback();
        wr_byte(1, 1'b0, 8'h34);
        wr_byte(1, 1'b0, 8'h12);
        bus.clr_ff = 1'b1;
        tick();
        rd_byte(1, 1'b0);
        checks++; if (bus.data_out !== 8'h34) begin failures++; $display("FAIL rd_lo got=%h exp=34", bus.data_out); end
        rd_byte(1, 1'b0);
        checks++; if (bus.data_out !== 8'h12) begin failures++; $display("FAIL rd_hi got=%h exp=12", bus.data_out); end
        bus.act_ch = 2'd1;
        #1;
        checks++; if (bus.Addr !== 16'h1234) begin failures++; $display("FAIL addr_ch1 got=%h exp=1234", bus.Addr); end
    endtask

    task automatic test_step_tc();
        logic [15:0] ea [3];
        logic [15:0] ew [3];
        logic        ep [3];
        ea = '{16'h0100, 16'h0101, 16'h0102};
        ew = '{16'h0001, 16'h0000, 16'hFFFF};
        ep = '{1'b0, 1'b0, 1'b1};
        wr_byte(0, 1'b0, 8'hFF); wr_byte(0, 1'b0, 8'h00);
        wr_byte(0, 1'b1, 8'h02); wr_byte(0, 1'b1, 8'h00);
        bus.addr_dec = 4'b0000; bus.autoinit = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            bus.act_ch = 2'd0; bus.xfer_step = 1'b1;
            tick();
            checks++; if (bus.Addr !== ea[i]) begin failures++; $display("FAIL step%0d_addr got=%h exp=%h", i, bus.Addr, ea[i]); end
            checks++; if (bus.WC !== ew[i]) begin failures++; $display("FAIL step%0d_wc got=%h exp=%h", i, bus.WC, ew[i]); end
            checks++; if (bus.tc_pulse !== ep[i]) begin failures++; $display("FAIL step%0d_pulse got=%b exp=%b", i, bus.tc_pulse, ep[i]); end
        end
        checks++; if (bus.TC !== 4'b0001) begin failures++; $display("FAIL step_tc got=%b exp=0001", bus.TC); end
        tick();
        checks++; if (bus.tc_pulse !== 1'b0) begin failures++; $display("FAIL pulse_width got=%b exp=0", bus.tc_pulse); end
    endtask

    task automatic test_autoinit();
        wr_byte(2, 1'b0, 8'h00); wr_byte(2, 1'b0, 8'h00);
        wr_byte(2, 1'b1, 8'h00); wr_byte(2, 1'b1, 8'h00);
        bus.addr_dec = 4'b0100; bus.autoinit = 4'b0100;
        bus.act_ch = 2'd2; bus.xfer_step = 1'b1;
        tick();
        checks++; if (bus.TC !== 4'b0101) begin failures++; $display("FAIL ai_tc got=%b exp=0101", bus.TC); end
        checks++; if (bus.tc_pulse !== 1'b1) begin failures++; $display("FAIL ai_pulse got=%b exp=1", bus.tc_pulse); end
        checks++; if (bus.Addr !== 16'h0000) begin failures++; $display("FAIL ai_addr got=%h exp=0000", bus.Addr); end
        checks++; if (bus.WC !== 16'h0000) begin failures++; $display("FAIL ai_wc got=%h exp=0000", bus.WC); end
    endtask

    task automatic test_status_race();
        bus.act_ch = 2'd3; bus.xfer_step = 1'b1; bus.status_rd = 1'b1;
        tick();
        checks++; if (bus.TC !== 4'b1000) begin failures++; $display("FAIL race_tc got=%b exp=1000", bus.TC); end
        checks++; if (bus.tc_pulse !== 1'b1) begin failures++; $display("FAIL race_pulse got=%b exp=1", bus.tc_pulse); end
        checks++; if (bus.WC !== 16'hFFFF) begin failures++; $display("FAIL race_wc got=%h exp=ffff", bus.WC); end
        checks++; if (bus.Addr !== 16'h0001) begin failures++; $display("FAIL race_addr got=%h exp=0001", bus.Addr); end
    endtask

    task automatic test_wr_step_collision();
        bus.prog_wr = 1'b1; bus.prog_sel.ch = 2'd1; bus.prog_sel.is_wc = 1'b1; bus.data_in = 8'h55;
        bus.act_ch = 2'd1; bus.xfer_step = 1'b1;
        tick();
        checks++; if (bus.Addr !== 16'h1234) begin failures++; $display("FAIL coll_addr got=%h exp=1234", bus.Addr); end
        checks++; if (bus.WC !== 16'h0055) begin failures++; $display("FAIL coll_wc got=%h exp=0055", bus.WC); end
        checks++; if (bus.tc_pulse !== 1'b0) begin failures++; $display("FAIL coll_pulse got=%b exp=0", bus.tc_pulse); end
        bus.prog_wr = 1'b1; bus.prog_sel.ch = 2'd1; bus.prog_sel.is_wc = 1'b1; bus.data_in = 8'h00;
        bus.act_ch = 2'd0; bus.xfer_step = 1'b1;
        tick();
        checks++; if (bus.Addr !== 16'h0103) begin failures++; $display("FAIL other_addr got=%h exp=0103", bus.Addr); end
        checks++; if (bus.WC !== 16'hFFFE) begin failures++; $display("FAIL other_wc got=%h exp=fffe", bus.WC); end
        bus.act_ch = 2'd1;
        #1;
        checks++; if (bus.WC !== 16'h0055) begin failures++; $display("FAIL coll_wc_hi got=%h exp=0055", bus.WC); end
    endtask

    task automatic test_mid_reset();
        wr_byte(0, 1'b0, 8'h11);
        bus.prog_wr = 1'b1; bus.prog_sel.ch = 2'd0; bus.prog_sel.is_wc = 1'b0; bus.data_in = 8'h77;
        #2 rst_n = 1'b0;
        #10;
        clear_strobes();
        mdl_clear();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.act_ch = 2'(i);
            #1;
            checks++; if (bus.Addr !== 16'h0 || bus.WC !== 16'h0) begin failures++; $display("FAIL mrst_ch%0d got=%h/%h exp=0000/0000", i, bus.Addr, bus.WC); end
        end
        checks++; if (bus.TC !== 4'h0) begin failures++; $display("FAIL mrst_tc got=%b exp=0000", bus.TC); end
        bus.act_ch = 2'd0;
        wr_byte(0, 1'b0, 8'hAB);
        checks++; if (bus.Addr !== 16'h00AB) begin failures++; $display("FAIL mrst_lowbyte got=%h exp=00ab", bus.Addr); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bus.prog_wr    = ($urandom_range(0, 3) == 0);
            bus.prog_rd    = ($urandom_range(0, 3) == 0);
            bus.prog_sel.ch    = 2'($urandom_range(0, 3));
            bus.prog_sel.is_wc = 1'($urandom_range(0, 1));
            bus.data_in    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            bus.clr_ff     = ($urandom_range(0, 7) == 0);
            bus.master_clr = ($urandom_range(0, 99) == 0);
            bus.status_rd  = ($urandom_range(0, 7) == 0);
            bus.xfer_step  = ($urandom_range(0, 1) == 1);
            bus.act_ch     = 2'($urandom_range(0, 3));
            if (n % 50 == 0) begin
                bus.addr_dec = 4'($urandom);
                bus.autoinit = 4'($urandom);
            end
            tick();
            checks++; if (bus.Addr !== m_ca[bus.act_ch]) begin failures++; $display("FAIL rnd%0d_addr got=%h exp=%h", n, bus.Addr, m_ca[bus.act_ch]); end
            checks++; if (bus.WC !== m_cw[bus.act_ch]) begin failures++; $display("FAIL rnd%0d_wc got=%h exp=%h", n, bus.WC, m_cw[bus.act_ch]); end
            checks++; if (bus.TC !== m_tc) begin failures++; $display("FAIL rnd%0d_tc got=%b exp=%b", n, bus.TC, m_tc); end
            checks++; if (bus.tc_pulse !== m_pulse) begin failures++; $display("FAIL rnd%0d_pulse got=%b exp=%b", n, bus.tc_pulse, m_pulse); end
            checks++; if (bus.data_out !== m_dout) begin failures++; $display("FAIL rnd%0d_dout got=%h exp=%h", n, bus.data_out, m_dout); end
        end
    endtask

    initial begin
        test_reset();
        test_prog_readback();
        test_step_tc();
        test_autoinit();
        test_status_race();
        test_wr_step_collision();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
